// File: rtl/ldpc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// ldpc_frame_ctrl : one-deep frame buffer and iteration control for an LDPC array
// Rev 1.0
// ============================================================================
module ldpc_frame_ctrl #(
   parameter int data_w = 8,
   parameter int R      = 24,
   parameter int C      = 12,
   parameter int D      = 24,
   parameter int IT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [R*D*data_w-1:0] in_llr,
   input  logic [IT_W-1:0]       max_iter,
   output logic                  arr_load,
   output logic [R*D*data_w-1:0] arr_llr,
   output logic                  arr_en,
   input  logic [R*D-1:0]        arr_dec,
   input  logic                  arr_check,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [R*D-1:0]        out_res,
   output logic                  out_err,
   output logic [IT_W-1:0]       out_iter
);

   localparam int   LLR_W   = R*D*data_w;
   localparam logic GEOM_OK = (C > 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_buf_full;
   logic [LLR_W-1:0]  r_buf_llr;
   logic [IT_W-1:0]   r_buf_max;
   logic [LLR_W-1:0]  r_llr_hold;
   logic [IT_W-1:0]   r_limit;
   logic [IT_W-1:0]   r_iter_cnt;
   logic [IT_W-1:0]   w_iter_inc;
   logic              w_accept;
   logic              w_hit_limit;

   // A degenerate geometry (no block columns) never accepts frames.
   assign in_ready    = !r_buf_full && GEOM_OK;
   assign w_accept    = in_valid && in_ready;
   assign w_iter_inc  = r_iter_cnt + 1'b1;
   assign w_hit_limit = (w_iter_inc == r_limit);
   assign arr_llr     = (r_state == S_LOAD) ? r_buf_llr : r_llr_hold;

   always_comb begin
      w_next    = r_state;
      arr_load  = 1'b0;
      arr_en    = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_buf_full) w_next = S_LOAD;
         end
         S_LOAD: begin
            arr_load = 1'b1;
            w_next   = S_ITER;
         end
         S_ITER: begin
            arr_en = 1'b1;
            if (arr_check || w_hit_limit) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = r_buf_full ? S_LOAD : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_buf_full <= 1'b0;
         r_buf_llr  <= '0;
         r_buf_max  <= '0;
         r_llr_hold <= '0;
         r_limit    <= '0;
         r_iter_cnt <= '0;
         out_res    <= '0;
         out_err    <= 1'b0;
         out_iter   <= '0;
      end else begin
         r_state <= w_next;

         if (w_accept) begin
            r_buf_llr <= in_llr;
            r_buf_max <= max_iter;
         end

         // A new accept wins over the LOAD-time clear so the fresh frame is kept.
         if (w_accept)
            r_buf_full <= 1'b1;
         else if (r_state == S_LOAD)
            r_buf_full <= 1'b0;

         case (r_state)
            S_LOAD: begin
               r_llr_hold <= r_buf_llr;
               r_limit    <= (r_buf_max == '0) ? IT_W'(1) : r_buf_max;
               r_iter_cnt <= '0;
            end
            S_ITER: begin
               if (arr_check) begin
                  out_res  <= arr_dec;
                  out_err  <= 1'b0;
                  out_iter <= w_iter_inc;
               end else if (w_hit_limit) begin
                  out_res  <= arr_dec;
                  out_err  <= 1'b1;
                  out_iter <= r_limit;
               end else begin
                  r_iter_cnt <= w_iter_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ldpc_frame_ctrl : directed self-checking bench for ldpc_frame_ctrl
// Rev 1.0
// ============================================================================
module tb_ldpc_frame_ctrl;

   localparam int DATA_W = 8;
   localparam int RR     = 24;
   localparam int CC     = 12;
   localparam int DD     = 24;
   localparam int ITW    = 8;
   localparam int LLR_W  = RR*DD*DATA_W;
   localparam int RES_W  = RR*DD;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [LLR_W-1:0] in_llr;
   logic [ITW-1:0]   max_iter;
   logic             arr_load;
   logic [LLR_W-1:0] arr_llr;
   logic             arr_en;
   logic [RES_W-1:0] arr_dec;
   logic             arr_check;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_res;
   logic             out_err;
   logic [ITW-1:0]   out_iter;

   int vectors     = 0;
   int miscompares = 0;

   ldpc_frame_ctrl #(
      .data_w(DATA_W), .R(RR), .C(CC), .D(DD), .IT_W(ITW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr), .max_iter(max_iter),
      .arr_load(arr_load), .arr_llr(arr_llr), .arr_en(arr_en),
      .arr_dec(arr_dec), .arr_check(arr_check),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_err(out_err), .out_iter(out_iter)
   );

   always #5 clk = ~clk;

   function automatic logic [LLR_W-1:0] mk_llr(input logic [31:0] s);
      return {(LLR_W/32){s}};
   endfunction

   function automatic logic [RES_W-1:0] mk_dec(input logic [31:0] s);
      return {(RES_W/32){s}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_llr = '0; max_iter = '0;
      arr_dec = '0; arr_check = 1'b0; out_ready = 1'b0;
      step(); step();
      vectors++;
      if ({out_valid, arr_load, arr_en, out_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got valid/load/en/err=%b want 0000", {out_valid, arr_load, arr_en, out_err});
      end
      vectors++;
      if (out_iter !== '0 || out_res !== '0 || arr_llr !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got iter=%0d res[31:0]=%h llr[31:0]=%h want zeros", out_iter, out_res[31:0], arr_llr[31:0]);
      end
      rst = 1'b0;
      step();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   // Single frame from an idle controller; arr_check rises in ITER cycle check_at (0 = never).
   task automatic run_frame(input string name, input logic [31:0] seed, input logic [ITW-1:0] mi,
                            input int check_at, input int exp_n, input logic exp_err,
                            input logic [ITW-1:0] exp_iter);
      logic [LLR_W-1:0] llr;
      logic [RES_W-1:0] exp_res;
      int n;
      int steps;
      bit done;
      llr     = mk_llr(seed);
      exp_res = mk_dec(seed + 32'(exp_n));
      in_valid = 1'b1; in_llr = llr; max_iter = mi;
      step();
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s accept: got in_ready=%b want 0", name, in_ready);
      end
      step();
      vectors++;
      if (arr_load !== 1'b1 || arr_en !== 1'b0 || arr_llr !== llr) begin
         miscompares++;
         $display("FAIL %s load: got load=%b en=%b llr[31:0]=%h want 1 0 %h", name, arr_load, arr_en, arr_llr[31:0], llr[31:0]);
      end
      n = 0; steps = 0; done = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         step();
         steps++;
         if (out_valid === 1'b1) begin
            done = 1'b1;
         end else begin
            if (arr_en === 1'b1) n++;
            arr_dec   = mk_dec(seed + 32'(n));
            arr_check = (n == check_at);
         end
      end
      arr_check = 1'b0;
      vectors++;
      if (!done || n != exp_n || steps != exp_n + 1) begin
         miscompares++;
         $display("FAIL %s latency: got done=%b en_cycles=%0d steps=%0d want 1 %0d %0d", name, done, n, steps, exp_n, exp_n + 1);
      end
      vectors++;
      if (out_iter !== exp_iter || out_err !== exp_err || out_res !== exp_res) begin
         miscompares++;
         $display("FAIL %s result: got iter=%0d err=%b res[31:0]=%h want %0d %b %h", name, out_iter, out_err, out_res[31:0], exp_iter, exp_err, exp_res[31:0]);
      end
      vectors++;
      if (arr_en !== 1'b0 || arr_llr !== llr) begin
         miscompares++;
         $display("FAIL %s done_hold: got en=%b llr[31:0]=%h want 0 %h", name, arr_en, arr_llr[31:0], llr[31:0]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s release: got valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [LLR_W-1:0] a, b;
      logic [RES_W-1:0] da;
      a = mk_llr(32'h1111_0001); b = mk_llr(32'h2222_0002); da = mk_dec(32'h0BAD_F00D);
      out_ready = 1'b1;
      in_valid = 1'b1; in_llr = a; max_iter = 8'd10;
      step();
      in_valid = 1'b0;
      step();
      step();
      vectors++;
      if (in_ready !== 1'b1 || arr_en !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_iter1: got in_ready=%b en=%b want 1 1", in_ready, arr_en);
      end
      in_valid = 1'b1; in_llr = b; max_iter = 8'd2;
      step();
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_b_held: got in_ready=%b want 0", in_ready);
      end
      arr_dec = da; arr_check = 1'b1;
      step();
      arr_check = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_iter !== 8'd2 || out_err !== 1'b0 || out_res !== da || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_a_done: got valid=%b iter=%0d err=%b in_ready=%b want 1 2 0 0", out_valid, out_iter, out_err, in_ready);
      end
      step();
      vectors++;
      if (arr_load !== 1'b1 || arr_llr !== b || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_b_load: got load=%b llr[31:0]=%h valid=%b in_ready=%b want 1 %h 0 0", arr_load, arr_llr[31:0], out_valid, in_ready, b[31:0]);
      end
      step();
      vectors++;
      if (in_ready !== 1'b1 || arr_en !== 1'b1 || arr_load !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_b_iter1: got in_ready=%b en=%b load=%b want 1 1 0", in_ready, arr_en, arr_load);
      end
      step();
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_iter !== 8'd2 || out_res !== da) begin
         miscompares++;
         $display("FAIL b2b_b_done: got valid=%b err=%b iter=%0d want 1 1 2", out_valid, out_err, out_iter);
      end
      step();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || arr_en !== 1'b0 || arr_load !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: got valid=%b en=%b load=%b want 0 0 0", out_valid, arr_en, arr_load);
      end
   endtask

   task automatic test_stall();
      logic [LLR_W-1:0] b;
      logic [RES_W-1:0] d;
      int bad;
      b = mk_llr(32'h3333_0003); d = mk_dec(32'hC0DE_0055);
      out_ready = 1'b0; arr_check = 1'b0; arr_dec = d;
      in_valid = 1'b1; in_llr = mk_llr(32'h4444_0004); max_iter = 8'd3;
      step();
      in_valid = 1'b0;
      step();
      step();
      in_valid = 1'b1; in_llr = b; max_iter = 8'd1;
      step();
      in_llr = mk_llr(32'h5555_0005); max_iter = 8'd4;
      step();
      step();
      arr_dec = ~d;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid !== 1'b1 || out_iter !== 8'd3 || out_err !== 1'b1 || out_res !== d || in_ready !== 1'b0) bad++;
         step();
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stall_hold: got %0d unstable cycles (valid=%b iter=%0d err=%b in_ready=%b) want 0", bad, out_valid, out_iter, out_err, in_ready);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (arr_load !== 1'b1 || arr_llr !== b || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_b_load: got load=%b llr[31:0]=%h in_ready=%b want 1 %h 0", arr_load, arr_llr[31:0], in_ready, b[31:0]);
      end
      step();
      step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_iter !== 8'd1 || out_err !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_b_done: got valid=%b iter=%0d err=%b in_ready=%b want 1 1 1 0", out_valid, out_iter, out_err, in_ready);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_iter !== '0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_reset_done: got valid=%b iter=%0d err=%b in_ready=%b want 0 0 0 1", out_valid, out_iter, out_err, in_ready);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_iter();
      int bad;
      in_valid = 1'b1; in_llr = mk_llr(32'h6666_0006); max_iter = 8'd10;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({arr_en, arr_load, out_valid, out_err} !== 4'b0000 || arr_llr !== '0 || out_res !== '0 || out_iter !== '0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_iter: got en=%b load=%b valid=%b llr[31:0]=%h in_ready=%b want 0 0 0 0 1", arr_en, arr_load, out_valid, arr_llr[31:0], in_ready);
      end
      step();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (out_valid !== 1'b0 || arr_en !== 1'b0 || arr_load !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL rst_discard: got %0d active cycles want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      run_frame("converge3",  32'hA000_0000, 8'd10,  3,   3,   1'b0, 8'd3);
      run_frame("limit5",     32'hB000_0000, 8'd5,   0,   5,   1'b1, 8'd5);
      run_frame("limit0",     32'hC000_0000, 8'd0,   0,   1,   1'b1, 8'd1);
      run_frame("priority",   32'hD000_0000, 8'd1,   1,   1,   1'b0, 8'd1);
      run_frame("limit255",   32'hE000_0000, 8'd255, 0,   255, 1'b1, 8'd255);
      run_frame("late_conv",  32'hF000_0000, 8'd255, 200, 200, 1'b0, 8'd200);
      test_back_to_back();
      test_stall();
      test_reset_mid_iter();
      run_frame("after_rst",  32'h1234_5678, 8'd6,   4,   4,   1'b0, 8'd4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
